// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared funct constants and multiply/divide sequencer states
// Purpose: constants and types shared by the execute-stage multiply/divide unit.
// Contents:
//   F_MULT..F_MTLO  funct field encodings handled by muldiv_unit
//   muldiv_state_t  sequencer state encoding (IDLE, MUL, DIV, FIX)
package mips_pkg;

  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MTLO  = 6'b010011;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    FIX  = 2'd3
  } muldiv_state_t;

endpackage

// File: rtl/muldiv_fsm.sv
// rtl/muldiv_fsm.sv - state/step-counter sequencer for the multiply/divide unit
// Purpose: decodes accepted commands and sequences the 32 iteration steps
//   followed by the fix-up cycle.
// Ports:
//   clk, reset   clock and asynchronous active-high reset
//   starte       execute-stage mult/div/mthi/mtlo valid
//   functe       funct field of the instruction
//   divzero      divisor operand is zero this cycle
//   state        current sequencer state
//   load         accept edge of mult/multu/div/divu (latch operands)
//   mthi_wr      accept edge of mthi
//   mtlo_wr      accept edge of mtlo
//   mul_step     perform one multiply step this cycle
//   div_step     perform one divide step this cycle
//   fix_en       apply sign fix-up and write HI/LO this cycle
//   busye        operation in flight
//   done         registered pulse in the cycle after HI/LO are written
module muldiv_fsm
  import mips_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          starte,
  input  logic [5:0]    functe,
  input  logic          divzero,
  output muldiv_state_t state,
  output logic          load,
  output logic          mthi_wr,
  output logic          mtlo_wr,
  output logic          mul_step,
  output logic          div_step,
  output logic          fix_en,
  output logic          busye,
  output logic          done
);

  localparam int CW = $clog2(WIDTH);

  muldiv_state_t state_next;
  logic [CW-1:0] count;
  logic          count_zero;
  logic          accept;
  logic          is_mul_cmd;
  logic          is_div_cmd;

  assign count_zero = (count == '0);
  assign accept     = starte && (state == IDLE);
  assign is_mul_cmd = (functe == F_MULT) || (functe == F_MULTU);
  assign is_div_cmd = (functe == F_DIV)  || (functe == F_DIVU);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      count <= '0;
      done  <= 1'b0;
    end else begin
      state <= state_next;
      done  <= (state == FIX);
      if (load) begin
        count <= CW'(WIDTH - 1);
      end else if ((state == MUL || state == DIV) && !count_zero) begin
        count <= count - 1'b1;
      end
    end
  end

  always_comb begin
    state_next = state;
    load       = 1'b0;
    mthi_wr    = 1'b0;
    mtlo_wr    = 1'b0;
    mul_step   = 1'b0;
    div_step   = 1'b0;
    fix_en     = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          if (is_mul_cmd) begin
            load       = 1'b1;
            state_next = MUL;
          end else if (is_div_cmd) begin
            load       = 1'b1;
            // A zero divisor bypasses the iteration entirely.
            state_next = divzero ? FIX : DIV;
          end else if (functe == F_MTHI) begin
            mthi_wr = 1'b1;
          end else if (functe == F_MTLO) begin
            mtlo_wr = 1'b1;
          end
        end
      end
      MUL: begin
        mul_step = 1'b1;
        if (count_zero) state_next = FIX;
      end
      DIV: begin
        div_step = 1'b1;
        if (count_zero) state_next = FIX;
      end
      FIX: begin
        fix_en     = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign busye = (state != IDLE);

endmodule

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative multiply/divide unit owning the HI/LO registers
// Purpose: 32-step shift-add multiplier and restoring divider for the
//   execute stage; stalls the pipeline via busye while iterating.
// Ports:
//   clk, reset   clock and asynchronous active-high reset
//   starte       execute-stage mult/div/mthi/mtlo valid
//   functe       funct field (mult, multu, div, divu, mthi, mtlo)
//   srcae        rs operand: multiplicand, dividend or mthi/mtlo data
//   srcbe        rt operand: multiplier or divisor
//   busye        operation in flight
//   done         one-cycle pulse after HI/LO are written by mult/div
//   hi, lo       architectural HI/LO registers
module muldiv_unit
  import mips_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             starte,
  input  logic [5:0]       functe,
  input  logic [WIDTH-1:0] srcae,
  input  logic [WIDTH-1:0] srcbe,
  output logic             busye,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  muldiv_state_t state;
  logic load, mthi_wr, mtlo_wr, mul_step, div_step, fix_en;
  logic divzero;

  // Operand decode for the accept cycle.
  logic             signed_op;
  logic             is_div_cmd;
  logic             sign_a, sign_b;
  logic [WIDTH-1:0] abs_a, abs_b;

  // Iteration state. acc holds the product for multiply, and the
  // remainder:quotient pair for divide; opb is multiplicand or divisor.
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   opb;
  logic               is_div;
  logic               dz;
  logic               neg_q;
  logic               neg_r;

  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shifted;
  logic [WIDTH:0]     div_diff;
  logic [2*WIDTH-1:0] prod_neg;
  logic [WIDTH-1:0]   quot_fix;
  logic [WIDTH-1:0]   rem_fix;

  assign divzero    = (srcbe == '0);
  assign signed_op  = (functe == F_MULT) || (functe == F_DIV);
  assign is_div_cmd = (functe == F_DIV)  || (functe == F_DIVU);
  assign sign_a     = signed_op && srcae[WIDTH-1];
  assign sign_b     = signed_op && srcbe[WIDTH-1];
  assign abs_a      = sign_a ? (~srcae + 1'b1) : srcae;
  assign abs_b      = sign_b ? (~srcbe + 1'b1) : srcbe;

  muldiv_fsm #(.WIDTH(WIDTH)) u_fsm (
    .clk      (clk),
    .reset    (reset),
    .starte   (starte),
    .functe   (functe),
    .divzero  (divzero),
    .state    (state),
    .load     (load),
    .mthi_wr  (mthi_wr),
    .mtlo_wr  (mtlo_wr),
    .mul_step (mul_step),
    .div_step (div_step),
    .fix_en   (fix_en),
    .busye    (busye),
    .done     (done)
  );

  // Multiply step: conditionally add the multiplicand into the upper half,
  // keeping the carry so the right shift does not lose it.
  assign mul_sum = acc[0] ? ({1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, opb})
                          : {1'b0, acc[2*WIDTH-1:WIDTH]};

  // Divide step: shift remainder:quotient left by one; the top bit of the
  // shifted remainder is kept so the trial subtract sees the full value.
  assign div_shifted = acc[2*WIDTH-1:WIDTH-1];
  assign div_diff    = div_shifted - {1'b0, opb};

  assign prod_neg = ~acc + 1'b1;
  assign quot_fix = neg_q ? (~acc[WIDTH-1:0] + 1'b1) : acc[WIDTH-1:0];
  assign rem_fix  = neg_r ? (~acc[2*WIDTH-1:WIDTH] + 1'b1) : acc[2*WIDTH-1:WIDTH];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc    <= '0;
      opb    <= '0;
      is_div <= 1'b0;
      dz     <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
    end else if (load) begin
      is_div <= is_div_cmd;
      dz     <= is_div_cmd && divzero;
      neg_q  <= sign_a ^ sign_b;
      neg_r  <= sign_a;
      if (is_div_cmd) begin
        // On divide-by-zero the raw dividend is kept so FIX can return it.
        acc <= {{WIDTH{1'b0}}, divzero ? srcae : abs_a};
        opb <= abs_b;
      end else begin
        acc <= {{WIDTH{1'b0}}, abs_b};
        opb <= abs_a;
      end
    end else if (mul_step) begin
      acc <= {mul_sum, acc[WIDTH-1:1]};
    end else if (div_step) begin
      if (!div_diff[WIDTH]) begin
        acc <= {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
      end else begin
        acc <= {div_shifted[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hi <= '0;
      lo <= '0;
    end else if (mthi_wr) begin
      hi <= srcae;
    end else if (mtlo_wr) begin
      lo <= srcae;
    end else if (fix_en) begin
      if (dz) begin
        hi <= acc[WIDTH-1:0];
        lo <= '1;
      end else if (is_div) begin
        hi <= rem_fix;
        lo <= quot_fix;
      end else if (neg_q) begin
        {hi, lo} <= prod_neg;
      end else begin
        {hi, lo} <= acc;
      end
    end
  end

endmodule
